// File: rtl/gmii_tx_arbiter.sv
// ============================================================================
// Module   : gmii_tx_arbiter
// Purpose  : Round-robin sharing of one GMII transmit port between two frame
//            sources, with IFG enforcement, start timeout and length guard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gmii_tx_arbiter #(
    parameter int IFG_BYTES     = 12,
    parameter int START_TIMEOUT = 64,
    parameter int MAX_FRAME     = 1530
) (
    input  logic        GMII_GTXCLK,
    input  logic        rst_n,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [7:0]  src0_txd,
    input  logic        src0_txen,
    input  logic        src0_txer,
    input  logic [7:0]  src1_txd,
    input  logic        src1_txen,
    input  logic        src1_txer,
    output logic [7:0]  GMII_TXD,
    output logic        GMII_TXEN,
    output logic        GMII_TXER,
    output logic        frame_done,
    output logic        err_timeout,
    output logic        err_overlong,
    output logic [15:0] frame_cnt
);

    // One counter is shared by the start timer, the frame length and the IFG.
    localparam int CNT_W = $clog2(MAX_FRAME + START_TIMEOUT + IFG_BYTES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(MAX_FRAME - 1);
    localparam logic [CNT_W-1:0] IFG_LAST     = CNT_W'(IFG_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_IFG   = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             last_winner, last_winner_d;
    logic [7:0]       txd_d;
    logic             txen_d, txer_d;
    logic             done_d, tmo_d, ovl_d;
    logic [15:0]      frame_cnt_d;

    logic [7:0]       sel_txd;
    logic             sel_txen, sel_txer, sel_req;
    logic             granted;

    // last_winner doubles as the selected source while GRANT/BUSY.
    assign sel_txd  = last_winner ? src1_txd  : src0_txd;
    assign sel_txen = last_winner ? src1_txen : src0_txen;
    assign sel_txer = last_winner ? src1_txer : src0_txer;
    assign sel_req  = last_winner ? req[1]    : req[0];
    assign granted  = (state == ST_GRANT) || (state == ST_BUSY);
    assign gnt      = granted ? (last_winner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge GMII_GTXCLK) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            last_winner  <= 1'b1;
            GMII_TXD     <= 8'h00;
            GMII_TXEN    <= 1'b0;
            GMII_TXER    <= 1'b0;
            frame_done   <= 1'b0;
            err_timeout  <= 1'b0;
            err_overlong <= 1'b0;
            frame_cnt    <= 16'h0000;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            last_winner  <= last_winner_d;
            GMII_TXD     <= txd_d;
            GMII_TXEN    <= txen_d;
            GMII_TXER    <= txer_d;
            frame_done   <= done_d;
            err_timeout  <= tmo_d;
            err_overlong <= ovl_d;
            frame_cnt    <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        last_winner_d = last_winner;
        txd_d         = 8'h00;
        txen_d        = 1'b0;
        txer_d        = 1'b0;
        done_d        = 1'b0;
        tmo_d         = 1'b0;
        ovl_d         = 1'b0;
        frame_cnt_d   = frame_cnt;

        if (granted) begin
            txd_d  = sel_txd;
            txen_d = sel_txen;
            txer_d = sel_txer;
        end

        case (state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    state_d       = ST_GRANT;
                    cnt_d         = '0;
                    last_winner_d = (req == 2'b11) ? ~last_winner : req[1];
                end
            end
            ST_GRANT: begin
                if (sel_txen) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_ONE;
                end else if (!sel_req) begin
                    state_d = ST_IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_d = ST_IFG;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            ST_BUSY: begin
                if (!sel_txen) begin
                    state_d     = ST_IFG;
                    cnt_d       = '0;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt + 16'd1;
                end else if (cnt == FRAME_LAST) begin
                    // This byte is the last allowed; mark it errored and cut the frame.
                    state_d = ST_IFG;
                    cnt_d   = '0;
                    ovl_d   = 1'b1;
                    txer_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            ST_IFG: begin
                // A truncated frame leaves TXEN high on entry; the gap starts once it drops.
                if (!GMII_TXEN) begin
                    if (cnt == IFG_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt + CNT_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire
